// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle control unit and the ALU: opcodes, ALU codes, states, mux selects.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package mc_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_RST = 4'd0,
        S_IF  = 4'd1,
        S_ID  = 4'd2,
        S_EXR = 4'd3,
        S_EXI = 4'd4,
        S_ADR = 4'd5,
        S_MRD = 4'd6,
        S_MWR = 4'd7,
        S_WBR = 4'd8,
        S_WBI = 4'd9,
        S_WBM = 4'd10,
        S_BR  = 4'd11,
        S_JMP = 4'd12
    } state_t;

    // ALU opcodes
    localparam logic [3:0] ALU_ADD  = 4'h0, ALU_ADDU = 4'h1, ALU_SUB  = 4'h2, ALU_SUBU = 4'h3;
    localparam logic [3:0] ALU_AND  = 4'h4, ALU_OR   = 4'h5, ALU_XOR  = 4'h6, ALU_NOR  = 4'h7;
    localparam logic [3:0] ALU_LUI  = 4'h8, ALU_SLL  = 4'h9, ALU_SRL  = 4'hA, ALU_SRA  = 4'hB;
    localparam logic [3:0] ALU_SLLV = 4'hC, ALU_SRLV = 4'hD, ALU_SRAV = 4'hE, ALU_PASSA = 4'hF;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU  = 6'h09, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E, OP_LUI    = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR   = 6'h08, F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27;

    // Datapath mux selects
    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_RS = 2'b01, SRCA_RT = 2'b10;
    localparam logic [1:0] SRCB_RT = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM2 = 2'b11;
    localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_RS = 2'b11;
    localparam logic [1:0] DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10;
    localparam logic [1:0] M2R_ALU = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;

    // Decode-stage dispatch; anything not recognised falls back to fetch as a nop.
    function automatic state_t id_next(input logic [5:0] op, input logic [5:0] funct, input logic [4:0] rt);
        state_t nxt;
        nxt = S_IF;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_JR, F_JALR: nxt = S_JMP;
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR: nxt = S_EXR;
                    default: nxt = S_IF;
                endcase
            end
            OP_LW, OP_SW:                      nxt = S_ADR;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:  nxt = S_BR;
            OP_REGIMM:                         nxt = (rt == 5'd0 || rt == 5'd1) ? S_BR : S_IF;
            OP_J, OP_JAL:                      nxt = S_JMP;
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: nxt = S_EXI;
            default:                           nxt = S_IF;
        endcase
        return nxt;
    endfunction

    function automatic logic [3:0] rfunct_alu(input logic [5:0] funct);
        logic [3:0] c;
        case (funct)
            F_ADD:  c = ALU_ADD;
            F_ADDU: c = ALU_ADDU;
            F_SUB:  c = ALU_SUB;
            F_SUBU: c = ALU_SUBU;
            F_AND:  c = ALU_AND;
            F_OR:   c = ALU_OR;
            F_XOR:  c = ALU_XOR;
            F_NOR:  c = ALU_NOR;
            F_SLL:  c = ALU_SLL;
            F_SRL:  c = ALU_SRL;
            F_SRA:  c = ALU_SRA;
            F_SLLV: c = ALU_SLLV;
            F_SRLV: c = ALU_SRLV;
            F_SRAV: c = ALU_SRAV;
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU control decode: (state, op, funct) -> alu_ctrl, alu_src_a, alu_src_b, ext_op.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs follow the state register directly.
module mc_alu_dec
    import mc_ctrl_fsm_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ext_op
);

    always_comb begin
        alu_ctrl  = ALU_ADD;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_RT;
        ext_op    = 1'b0;
        case (state)
            S_IF: begin
                alu_src_b = SRCB_4;
            end
            S_ID: begin
                // Speculative branch target into ALUOut
                alu_src_b = SRCB_IMM2;
                ext_op    = 1'b1;
            end
            S_EXR: begin
                alu_ctrl = rfunct_alu(funct);
                // Fixed shifts shift rt by shamt, which reaches the ALU as imm[10:6]
                if (funct == F_SLL || funct == F_SRL || funct == F_SRA) begin
                    alu_src_a = SRCA_RT;
                    alu_src_b = SRCB_IMM;
                end else begin
                    alu_src_a = SRCA_RS;
                    alu_src_b = SRCB_RT;
                end
            end
            S_EXI: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_ADDI:  begin alu_ctrl = ALU_ADD;  ext_op = 1'b1; end
                    OP_ADDIU: begin alu_ctrl = ALU_ADDU; ext_op = 1'b1; end
                    OP_ANDI:  alu_ctrl = ALU_AND;
                    OP_ORI:   alu_ctrl = ALU_OR;
                    OP_XORI:  alu_ctrl = ALU_XOR;
                    OP_LUI:   alu_ctrl = ALU_LUI;
                    default:  alu_ctrl = ALU_ADD;
                endcase
            end
            S_ADR: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_IMM;
                ext_op    = 1'b1;
            end
            S_BR: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_RT;
                // Equality branches compare rs-rt; sign tests only look at rs
                alu_ctrl  = (op == OP_BEQ || op == OP_BNE) ? ALU_SUB : ALU_PASSA;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath enables.
// Latency (mem_ready high): R/I-ALU 4, lw 5, sw 4, branch 3, jump 3 cycles.
// Backpressure: S_IF, S_MRD and S_MWR hold with the request asserted until mem_ready.
// Ports: clk/rst_n; IR fields op/funct/rt; alu_flags {neg,pos,zero}; mem_ready;
//        ALU control (alu_ctrl, alu_src_a/b, ext_op); PC/IR/memory/regfile controls; state_o debug.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int OPW = 6,
    parameter int ACW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] op,
    input  logic [OPW-1:0] funct,
    input  logic [4:0]     rt,
    input  logic [2:0]     alu_flags,
    input  logic           mem_ready,
    output logic [ACW-1:0] alu_ctrl,
    output logic [1:0]     alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic           ext_op,
    output logic           pc_we,
    output logic [1:0]     pc_src,
    output logic           ir_we,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           iord,
    output logic           reg_we,
    output logic [1:0]     reg_dst,
    output logic [1:0]     mem_to_reg,
    output logic [3:0]     state_o
);

    state_t state, state_n;
    logic   br_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RST;
        else        state <= state_n;
    end

    assign state_o = state;

    mc_alu_dec u_alu_dec (
        .state     (state),
        .op        (op),
        .funct     (funct),
        .alu_ctrl  (alu_ctrl),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .ext_op    (ext_op)
    );

    // flags: [0] zero, [1] positive nonzero, [2] negative
    always_comb begin
        br_taken = 1'b0;
        case (op)
            OP_BEQ:    br_taken = alu_flags[0];
            OP_BNE:    br_taken = !alu_flags[0];
            OP_BGTZ:   br_taken = alu_flags[1];
            OP_BLEZ:   br_taken = alu_flags[0] | alu_flags[2];
            OP_REGIMM: begin
                if (rt == 5'd0)      br_taken = alu_flags[2];
                else if (rt == 5'd1) br_taken = alu_flags[0] | alu_flags[1];
                else                 br_taken = 1'b0;
            end
            default:   br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_n    = state;
        pc_we      = 1'b0;
        pc_src     = PCSRC_ALU;
        ir_we      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = M2R_ALU;
        case (state)
            S_RST: state_n = S_IF;
            S_IF: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    pc_we   = 1'b1;
                    ir_we   = 1'b1;
                    state_n = S_ID;
                end
            end
            S_ID:  state_n = id_next(op, funct, rt);
            S_EXR: state_n = S_WBR;
            S_EXI: state_n = S_WBI;
            S_ADR: state_n = (op == OP_LW) ? S_MRD : S_MWR;
            S_MRD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                if (mem_ready) state_n = S_WBM;
            end
            S_MWR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
                if (mem_ready) state_n = S_IF;
            end
            S_WBR: begin
                reg_we  = 1'b1;
                reg_dst = DST_RD;
                state_n = S_IF;
            end
            S_WBI: begin
                reg_we  = 1'b1;
                state_n = S_IF;
            end
            S_WBM: begin
                reg_we     = 1'b1;
                mem_to_reg = M2R_MDR;
                state_n    = S_IF;
            end
            S_BR: begin
                // ALUOut still holds the target computed during decode
                if (br_taken) begin
                    pc_we  = 1'b1;
                    pc_src = PCSRC_ALUOUT;
                end
                state_n = S_IF;
            end
            S_JMP: begin
                pc_we = 1'b1;
                // PC already holds PC+4, so the link value comes from PC
                if (op == OP_RTYPE) begin
                    pc_src = PCSRC_RS;
                    if (funct == F_JALR) begin
                        reg_we     = 1'b1;
                        reg_dst    = DST_RD;
                        mem_to_reg = M2R_PC;
                    end
                end else begin
                    pc_src = PCSRC_JUMP;
                    if (op == OP_JAL) begin
                        reg_we     = 1'b1;
                        reg_dst    = DST_RA;
                        mem_to_reg = M2R_PC;
                    end
                end
                state_n = S_IF;
            end
            default: state_n = S_RST;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-cycle expected outputs queued alongside stimulus, compared at the falling edge.
// Latency: n/a.
// Backpressure: mem_ready driven per cycle from the stimulus queue.
module tb_mc_ctrl_fsm;
    import mc_ctrl_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic [4:0] rt;
    logic [2:0] alu_flags;
    logic       mem_ready;
    logic [3:0] alu_ctrl;
    logic [1:0] alu_src_a, alu_src_b;
    logic       ext_op, pc_we;
    logic [1:0] pc_src;
    logic       ir_we, mem_rd, mem_wr, iord, reg_we;
    logic [1:0] reg_dst, mem_to_reg;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .rt(rt),
        .alu_flags(alu_flags), .mem_ready(mem_ready),
        .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_op(ext_op), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord), .reg_we(reg_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state_o(state_o)
    );

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] alu;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       ext;
        logic       pcwe;
        logic [1:0] pcsrc;
        logic       irwe;
        logic       mrd;
        logic       mwr;
        logic       iord;
        logic       regwe;
        logic [1:0] dst;
        logic [1:0] m2r;
    } obs_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic [4:0] rt;
        logic [2:0] flags;
        logic       rdy;
    } stim_t;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;

    logic [5:0] cur_op, cur_funct;
    logic [4:0] cur_rt;
    logic [2:0] cur_flags;

    function automatic obs_t observe();
        return {state_o, alu_ctrl, alu_src_a, alu_src_b, ext_op, pc_we, pc_src,
                ir_we, mem_rd, mem_wr, iord, reg_we, reg_dst, mem_to_reg};
    endfunction

    function automatic obs_t mk(input state_t s);
        obs_t e;
        e = '0;
        e.st = s;
        return e;
    endfunction

    task automatic set_instr(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r, input logic [2:0] fl);
        cur_op = o; cur_funct = f; cur_rt = r; cur_flags = fl;
    endtask

    task automatic push(input string nm, input logic rdy, input obs_t e);
        stim_q.push_back({cur_op, cur_funct, cur_rt, cur_flags, rdy});
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic push_if(input string nm, input logic rdy);
        obs_t e;
        e = mk(S_IF);
        e.sb = 2'b01; e.mrd = 1'b1; e.pcwe = rdy; e.irwe = rdy;
        push(nm, rdy, e);
    endtask

    task automatic push_id(input string nm);
        obs_t e;
        e = mk(S_ID);
        e.sb = 2'b11; e.ext = 1'b1;
        push(nm, 1'b1, e);
    endtask

    // Drives each queued cycle just after the rising edge, checks at the falling edge.
    task automatic run_q();
        stim_t s;
        obs_t  e, o;
        string nm;
        while (stim_q.size() > 0) begin
            s  = stim_q.pop_front();
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            op = s.op; funct = s.funct; rt = s.rt; alu_flags = s.flags; mem_ready = s.rdy;
            @(negedge clk);
            o = observe();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", nm, o, o.st, e, e.st);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0; op = '0; funct = '0; rt = '0; alu_flags = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        o = observe();
        tests++;
        if (o !== mk(S_RST)) begin
            fails++;
            $display("FAIL reset_state: got %h expected %h", o, mk(S_RST));
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_instr(6'h00, 6'h00, 5'd0, 3'b000);
        push_if("reset_release_if", 1'b0);
        run_q();
    endtask

    task automatic test_add();
        obs_t e;
        set_instr(OP_RTYPE, F_ADD, 5'd2, 3'b000);
        push_if("add_if", 1'b1);
        push_id("add_id");
        e = mk(S_EXR); e.alu = 4'h0; e.sa = 2'b01; e.sb = 2'b00;
        push("add_exr", 1'b1, e);
        e = mk(S_WBR); e.regwe = 1'b1; e.dst = 2'b01; e.m2r = 2'b00;
        push("add_wbr", 1'b1, e);
        run_q();
    endtask

    task automatic test_shifts();
        obs_t e;
        set_instr(OP_RTYPE, F_SLL, 5'd1, 3'b000);
        push_if("sll_if", 1'b1);
        push_id("sll_id");
        e = mk(S_EXR); e.alu = 4'h9; e.sa = 2'b10; e.sb = 2'b10;
        push("sll_exr", 1'b1, e);
        e = mk(S_WBR); e.regwe = 1'b1; e.dst = 2'b01;
        push("sll_wbr", 1'b1, e);
        run_q();
        set_instr(OP_RTYPE, F_SRAV, 5'd1, 3'b000);
        push_if("srav_if", 1'b1);
        push_id("srav_id");
        e = mk(S_EXR); e.alu = 4'hE; e.sa = 2'b01; e.sb = 2'b00;
        push("srav_exr", 1'b1, e);
        e = mk(S_WBR); e.regwe = 1'b1; e.dst = 2'b01;
        push("srav_wbr", 1'b1, e);
        run_q();
    endtask

    task automatic test_lw_wait();
        obs_t e;
        set_instr(OP_LW, 6'h00, 5'd4, 3'b000);
        push_if("lw_if", 1'b1);
        push_id("lw_id");
        e = mk(S_ADR); e.sa = 2'b01; e.sb = 2'b10; e.ext = 1'b1;
        push("lw_adr", 1'b1, e);
        for (int i = 0; i < 4; i++) begin
            e = mk(S_MRD); e.mrd = 1'b1; e.iord = 1'b1;
            push($sformatf("lw_mrd_%0d", i), (i == 3), e);
        end
        e = mk(S_WBM); e.regwe = 1'b1; e.dst = 2'b00; e.m2r = 2'b01;
        push("lw_wbm", 1'b1, e);
        run_q();
    endtask

    task automatic branch(input string nm, input logic [5:0] o, input logic [4:0] r,
                          input logic [2:0] fl, input logic [3:0] alu, input logic taken);
        obs_t e;
        set_instr(o, 6'h00, r, fl);
        push_if({nm, "_if"}, 1'b1);
        push_id({nm, "_id"});
        e = mk(S_BR); e.alu = alu; e.sa = 2'b01; e.sb = 2'b00;
        e.pcwe = taken; e.pcsrc = taken ? 2'b01 : 2'b00;
        push({nm, "_br"}, 1'b1, e);
        run_q();
    endtask

    task automatic test_branches();
        branch("beq_t",   OP_BEQ,    5'd0, 3'b001, 4'h2, 1'b1);
        branch("bne_nt",  OP_BNE,    5'd0, 3'b001, 4'h2, 1'b0);
        branch("bgtz_nt", OP_BGTZ,   5'd0, 3'b100, 4'hF, 1'b0);
        branch("blez_t",  OP_BLEZ,   5'd0, 3'b100, 4'hF, 1'b1);
        branch("bgez_t",  OP_REGIMM, 5'd1, 3'b010, 4'hF, 1'b1);
        branch("bltz_nt", OP_REGIMM, 5'd0, 3'b010, 4'hF, 1'b0);
    endtask

    task automatic test_jumps();
        obs_t e;
        set_instr(OP_JAL, 6'h00, 5'd0, 3'b000);
        push_if("jal_if", 1'b1);
        push_id("jal_id");
        e = mk(S_JMP); e.pcwe = 1'b1; e.pcsrc = 2'b10; e.regwe = 1'b1; e.dst = 2'b10; e.m2r = 2'b10;
        push("jal_jmp", 1'b1, e);
        run_q();
        set_instr(OP_RTYPE, F_JR, 5'd0, 3'b000);
        push_if("jr_if", 1'b1);
        push_id("jr_id");
        e = mk(S_JMP); e.pcwe = 1'b1; e.pcsrc = 2'b11;
        push("jr_jmp", 1'b1, e);
        run_q();
    endtask

    task automatic itype(input string nm, input logic [5:0] o, input logic [3:0] alu, input logic ext);
        obs_t e;
        set_instr(o, 6'h15, 5'd7, 3'b000);
        push_if({nm, "_if"}, 1'b1);
        push_id({nm, "_id"});
        e = mk(S_EXI); e.alu = alu; e.sa = 2'b01; e.sb = 2'b10; e.ext = ext;
        push({nm, "_exi"}, 1'b1, e);
        e = mk(S_WBI); e.regwe = 1'b1; e.dst = 2'b00;
        push({nm, "_wbi"}, 1'b1, e);
    endtask

    task automatic test_back_to_back();
        itype("addi", OP_ADDI, 4'h0, 1'b1);
        itype("ori",  OP_ORI,  4'h5, 1'b0);
        itype("lui",  OP_LUI,  4'h8, 1'b0);
        run_q();
    endtask

    task automatic test_illegal();
        set_instr(6'h3F, 6'h00, 5'd0, 3'b000);
        push_if("illegal_if", 1'b1);
        push_id("illegal_id");
        run_q();
    endtask

    task automatic test_sw_reset();
        obs_t e, o;
        set_instr(OP_SW, 6'h00, 5'd3, 3'b000);
        push_if("sw_if", 1'b1);
        push_id("sw_id");
        e = mk(S_ADR); e.sa = 2'b01; e.sb = 2'b10; e.ext = 1'b1;
        push("sw_adr", 1'b1, e);
        e = mk(S_MWR); e.mwr = 1'b1; e.iord = 1'b1;
        push("sw_mwr", 1'b0, e);
        run_q();
        // Still in S_MWR waiting on memory; abort asynchronously between edges
        mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        o = observe();
        tests++;
        if (o !== mk(S_RST)) begin
            fails++;
            $display("FAIL sw_abort: got %h expected %h (mem_wr=%b)", o, mk(S_RST), mem_wr);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_if("abort_restart_if", 1'b1);
        run_q();
    endtask

    initial begin
        cur_op = '0; cur_funct = '0; cur_rt = '0; cur_flags = '0;
        test_reset();
        test_add();
        test_shifts();
        test_lw_wait();
        test_branches();
        test_jumps();
        test_back_to_back();
        test_illegal();
        test_sw_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog: the stimulus is finite, this only guards against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit 200000", $time);
        $fatal(1);
    end

endmodule
